pkc_flow_ctrl: RTL and testbench

//  Top-level sequencer for the code-based PKC datapath: keyGen -> Encryption -> Decryption.
//  - Issues one-cycle start pulses to each engine and waits for its ready flag.
//  - Guards every phase with a timeout.
//  - Captures the plaintext and checks the decrypted message against it (round-trip self-test).
//  - Can reuse a cached public key and skip keyGen.
//  - Supports abort, and resets the engines through a dedicated sub-reset.

---
 rtl/pkc_flow_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pkc_flow_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkc_flow_ctrl.sv
// Round-trip sequencer for the code-based PKC datapath: keyGen -> Encryption -> Decryption -> check.
// Each engine phase is started by a one-cycle pulse, guarded by a timeout and abortable.
module pkc_flow_ctrl #(
  parameter int unsigned MSG_W   = 16,
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = 40000,
  parameter int unsigned CYC_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_start,
  input  logic             i_cmd_reuse,
  input  logic             i_cmd_abort,
  input  logic [MSG_W-1:0] i_msg_in,
  input  logic             i_key_ready,
  input  logic             i_cipher_ready,
  input  logic             i_dec_ready,
  input  logic [MSG_W-1:0] i_dec_msg,
  output logic             o_kg_start,
  output logic             o_enc_start,
  output logic             o_dec_start,
  output logic             o_sub_rst_n,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_err,
  output logic [1:0]       o_err_phase,
  output logic             o_key_cached,
  output logic [CYC_W-1:0] o_run_cycles
);

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StKg, StEnc, StDec, StChk, StDone, StErr} state_e;

  state_e           r_state;
  logic             r_kg_start;
  logic             r_enc_start;
  logic             r_dec_start;
  logic             r_sub_rst_n;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_err;
  logic [1:0]       r_err_phase;
  logic             r_key_cached;
  logic [CYC_W-1:0] r_run_cycles;
  logic [TO_W-1:0]  r_to_cnt;
  logic [MSG_W-1:0] r_msg;
  logic [MSG_W-1:0] r_dec_msg;

  logic             w_rdy;
  logic             w_first;
  logic [1:0]       w_phase;
  logic             w_to_hit;
  logic             w_match;

  // Ready/first-cycle/phase code of whichever engine phase is active. The start pulse register
  // doubles as the entry-cycle marker so a ready left high from a previous run is not taken.
  always_comb begin
    w_rdy   = 1'b0;
    w_first = 1'b0;
    w_phase = 2'd0;
    case (r_state)
      StKg: begin
        w_rdy   = i_key_ready;
        w_first = r_kg_start;
        w_phase = 2'd1;
      end
      StEnc: begin
        w_rdy   = i_cipher_ready;
        w_first = r_enc_start;
        w_phase = 2'd2;
      end
      StDec: begin
        w_rdy   = i_dec_ready;
        w_first = r_dec_start;
        w_phase = 2'd3;
      end
      default: ;
    endcase
  end

  assign w_to_hit = (r_to_cnt == ToLast);
  assign w_match  = (r_dec_msg == r_msg);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_kg_start   <= 1'b0;
      r_enc_start  <= 1'b0;
      r_dec_start  <= 1'b0;
      r_sub_rst_n  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= 1'b0;
      r_err_phase  <= 2'd0;
      r_key_cached <= 1'b0;
      r_run_cycles <= '0;
      r_to_cnt     <= '0;
      r_msg        <= '0;
      r_dec_msg    <= '0;
    end else begin
      r_kg_start  <= 1'b0;
      r_enc_start <= 1'b0;
      r_dec_start <= 1'b0;
      r_sub_rst_n <= 1'b1;
      if (r_busy && (r_run_cycles != '1)) begin
        r_run_cycles <= r_run_cycles + CYC_W'(1);
      end

      if (i_cmd_abort && r_busy) begin
        r_state      <= StIdle;
        r_busy       <= 1'b0;
        r_sub_rst_n  <= 1'b0;
        r_key_cached <= 1'b0;
        r_err_phase  <= 2'd0;
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_err        <= 1'b0;
        r_to_cnt     <= '0;
      end else begin
        case (r_state)
          StIdle, StDone, StErr: begin
            // An abort arriving with the start drops the start even when idle.
            if (i_cmd_start && !i_cmd_abort) begin
              r_msg        <= i_msg_in;
              r_run_cycles <= '0;
              r_to_cnt     <= '0;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
              r_pass       <= 1'b0;
              r_err        <= 1'b0;
              r_err_phase  <= 2'd0;
              if (i_cmd_reuse && r_key_cached) begin
                r_state     <= StEnc;
                r_enc_start <= 1'b1;
              end else begin
                r_state    <= StKg;
                r_kg_start <= 1'b1;
              end
            end
          end
          StKg, StEnc, StDec: begin
            if (w_rdy && !w_first) begin
              r_to_cnt <= '0;
              case (r_state)
                StKg: begin
                  r_state      <= StEnc;
                  r_enc_start  <= 1'b1;
                  r_key_cached <= 1'b1;
                end
                StEnc: begin
                  r_state     <= StDec;
                  r_dec_start <= 1'b1;
                end
                default: begin
                  r_state   <= StChk;
                  r_dec_msg <= i_dec_msg;
                end
              endcase
            end else if (w_to_hit) begin
              r_state      <= StErr;
              r_busy       <= 1'b0;
              r_err        <= 1'b1;
              r_err_phase  <= w_phase;
              r_sub_rst_n  <= 1'b0;
              r_key_cached <= 1'b0;
              r_to_cnt     <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          StChk: begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_match;
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_kg_start   = r_kg_start;
  assign o_enc_start  = r_enc_start;
  assign o_dec_start  = r_dec_start;
  assign o_sub_rst_n  = r_sub_rst_n;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err        = r_err;
  assign o_err_phase  = r_err_phase;
  assign o_key_cached = r_key_cached;
  assign o_run_cycles = r_run_cycles;

endmodule

// File: tb/tb_pkc_flow_ctrl.sv
// Bench for pkc_flow_ctrl: behavioural engines with programmable ready delay, and a scoreboard
// of expected run results that is popped when the DUT reaches DONE or ERR.
module tb_pkc_flow_ctrl;
  localparam int unsigned MsgW = 16;
  localparam int unsigned ToW = 16;
  localparam int unsigned Timeout = 8;
  localparam int unsigned CycW = 32;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        err;
    logic [1:0]  phase;
    logic [31:0] cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cmd_start = 1'b0;
  logic            cmd_reuse = 1'b0;
  logic            cmd_abort = 1'b0;
  logic [MsgW-1:0] msg_in = '0;
  logic [MsgW-1:0] dec_msg = '0;
  logic            key_ready, cipher_ready, dec_ready;
  logic            kg_start, enc_start, dec_start, sub_rst_n;
  logic            busy, done, pass, err, key_cached;
  logic [1:0]      err_phase;
  logic [CycW-1:0] run_cycles;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   pulse_log[$];

  // Engine models: ready drops on the start pulse and rises dly cycles later (dly 0 = never).
  int   kg_dly = 3, enc_dly = 3, dec_dly = 3;
  int   kg_cnt = 0, enc_cnt = 0, dec_cnt = 0;
  logic kr_model = 1'b0, cr_model = 1'b0, dr_model = 1'b0, kr_hold = 1'b0;

  assign key_ready    = kr_model | kr_hold;
  assign cipher_ready = cr_model;
  assign dec_ready    = dr_model;

  always #5 clk = ~clk;

  pkc_flow_ctrl #(
    .MSG_W  (MsgW),
    .TO_W   (ToW),
    .TIMEOUT(Timeout),
    .CYC_W  (CycW)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset_n),
    .i_cmd_start   (cmd_start),
    .i_cmd_reuse   (cmd_reuse),
    .i_cmd_abort   (cmd_abort),
    .i_msg_in      (msg_in),
    .i_key_ready   (key_ready),
    .i_cipher_ready(cipher_ready),
    .i_dec_ready   (dec_ready),
    .i_dec_msg     (dec_msg),
    .o_kg_start    (kg_start),
    .o_enc_start   (enc_start),
    .o_dec_start   (dec_start),
    .o_sub_rst_n   (sub_rst_n),
    .o_busy        (busy),
    .o_done        (done),
    .o_pass        (pass),
    .o_err         (err),
    .o_err_phase   (err_phase),
    .o_key_cached  (key_cached),
    .o_run_cycles  (run_cycles)
  );

  always @(negedge clk) begin
    if (!sub_rst_n) begin
      kr_model = 1'b0; cr_model = 1'b0; dr_model = 1'b0;
      kg_cnt = 0; enc_cnt = 0; dec_cnt = 0;
    end else begin
      if (kg_start) begin
        kr_model = 1'b0; kg_cnt = kg_dly; pulse_log.push_back(1);
      end else if (kg_cnt > 0) begin
        kg_cnt--; if (kg_cnt == 0) kr_model = 1'b1;
      end
      if (enc_start) begin
        cr_model = 1'b0; enc_cnt = enc_dly; pulse_log.push_back(2);
      end else if (enc_cnt > 0) begin
        enc_cnt--; if (enc_cnt == 0) cr_model = 1'b1;
      end
      if (dec_start) begin
        dr_model = 1'b0; dec_cnt = dec_dly; pulse_log.push_back(3);
      end else if (dec_cnt > 0) begin
        dec_cnt--; if (dec_cnt == 0) dr_model = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for DONE or ERR; index 0 is the cycle right after the accepted start.
  task automatic wait_end(output bit timed_out, output int idx_end, output int idx_enc);
    timed_out = 1'b1;
    idx_end   = -1;
    idx_enc   = -1;
    for (int i = 1; i < 200; i++) begin
      tick();
      if (enc_start) idx_enc = i;
      if (done || err) begin
        timed_out = 1'b0;
        idx_end   = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({kg_start, enc_start, dec_start, busy, done, pass, err, err_phase, key_cached} !== '0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0",
               {kg_start, enc_start, dec_start, busy, done, pass, err, err_phase, key_cached});
    end
    checks++;
    if (run_cycles !== '0) begin
      errors++; $display("FAIL reset_run_cycles got %0d want 0", run_cycles);
    end
    checks++;
    if (sub_rst_n !== 1'b1) begin
      errors++; $display("FAIL reset_sub_rst_n got %b want 1", sub_rst_n);
    end
    reset_n   = 1'b1;
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    tick();
    checks++;
    if ({sub_rst_n, busy, done, err, kg_start} !== 5'b10000) begin
      errors++;
      $display("FAIL idle_abort got %b want 10000", {sub_rst_n, busy, done, err, kg_start});
    end
  endtask

  task automatic test_run(input string name, input logic [15:0] msg, input logic [15:0] dmsg,
                          input bit reuse, input logic [2:0] exp_first, input int exp_cyc,
                          input bit exp_pass, input int exp_seq);
    bit   to;
    int   idx_end, idx_enc, n0, seq;
    exp_t e;
    sb.push_back('{done: 1'b1, pass: exp_pass, err: 1'b0, phase: 2'd0, cyc: 32'(exp_cyc)});
    n0        = pulse_log.size();
    cmd_start = 1'b1;
    cmd_reuse = reuse;
    msg_in    = msg;
    dec_msg   = dmsg;
    tick();
    cmd_start = 1'b0;
    cmd_reuse = 1'b0;
    checks++;
    if ({kg_start, enc_start, dec_start} !== exp_first) begin
      errors++;
      $display("FAIL %s first_pulse got %b want %b", name, {kg_start, enc_start, dec_start},
               exp_first);
    end
    checks++;
    if ({done, pass, err, err_phase, busy} !== 6'b000001) begin
      errors++;
      $display("FAIL %s start_clear got %b want 000001", name, {done, pass, err, err_phase, busy});
    end
    wait_end(to, idx_end, idx_enc);
    checks++;
    if (to) begin
      errors++; $display("FAIL %s completion got timeout want done", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({done, pass, err, err_phase} !== {e.done, e.pass, e.err, e.phase}) begin
        errors++;
        $display("FAIL %s result got %b want %b", name, {done, pass, err, err_phase},
                 {e.done, e.pass, e.err, e.phase});
      end
      checks++;
      if (run_cycles !== e.cyc) begin
        errors++; $display("FAIL %s run_cycles got %0d want %0d", name, run_cycles, e.cyc);
      end
    end
    tick();
    seq = 0;
    for (int k = n0; k < pulse_log.size(); k++) seq = seq * 10 + pulse_log[k];
    checks++;
    if (seq != exp_seq) begin
      errors++; $display("FAIL %s pulse_order got %0d want %0d", name, seq, exp_seq);
    end
    checks++;
    if ({done, busy, key_cached} !== 3'b101) begin
      errors++; $display("FAIL %s done_hold got %b want 101", name, {done, busy, key_cached});
    end
  endtask

  task automatic test_timeout();
    bit   to;
    int   idx_end, idx_enc;
    exp_t e;
    kg_dly  = 3;
    enc_dly = 0;
    sb.push_back('{done: 1'b0, pass: 1'b0, err: 1'b1, phase: 2'd2, cyc: 32'd12});
    cmd_start = 1'b1;
    msg_in    = 16'h3C3C;
    tick();
    cmd_start = 1'b0;
    wait_end(to, idx_end, idx_enc);
    checks++;
    if (to) begin
      errors++; $display("FAIL timeout completion got timeout want err");
    end else begin
      e = sb.pop_front();
      checks++;
      if ({done, pass, err, err_phase} !== {e.done, e.pass, e.err, e.phase}) begin
        errors++;
        $display("FAIL timeout result got %b want %b", {done, pass, err, err_phase},
                 {e.done, e.pass, e.err, e.phase});
      end
      checks++;
      if (run_cycles !== e.cyc) begin
        errors++; $display("FAIL timeout run_cycles got %0d want %0d", run_cycles, e.cyc);
      end
      checks++;
      if (idx_end - idx_enc != 8) begin
        errors++;
        $display("FAIL timeout enc_to_err got %0d want 8 cycles", idx_end - idx_enc);
      end
      checks++;
      if ({sub_rst_n, key_cached, busy} !== 3'b000) begin
        errors++;
        $display("FAIL timeout sub_rst got %b want 000", {sub_rst_n, key_cached, busy});
      end
    end
    tick();
    checks++;
    if ({sub_rst_n, err, err_phase} !== 4'b1110) begin
      errors++;
      $display("FAIL timeout sub_rst_release got %b want 1110", {sub_rst_n, err, err_phase});
    end
    enc_dly = 3;
  endtask

  task automatic test_abort();
    bit found;
    int n0;
    found     = 1'b0;
    cmd_start = 1'b1;
    msg_in    = 16'h0001;
    tick();
    cmd_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (dec_start) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL abort reach_dec got no dec_start want dec_start");
    end
    tick();
    n0        = pulse_log.size();
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    tick();
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    checks++;
    if ({busy, sub_rst_n, key_cached, done, pass, err, err_phase} !== '0) begin
      errors++;
      $display("FAIL abort state got %b want 0",
               {busy, sub_rst_n, key_cached, done, pass, err, err_phase});
    end
    repeat (3) tick();
    checks++;
    if ({sub_rst_n, busy, 32'(pulse_log.size() - n0)} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL abort no_restart got sub_rst_n=%b busy=%b pulses=%0d want 1 0 0",
               sub_rst_n, busy, pulse_log.size() - n0);
    end
  endtask

  task automatic test_entry_ready();
    kg_dly    = 0;
    kr_hold   = 1'b1;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checks++;
    if (kg_start !== 1'b1) begin
      errors++; $display("FAIL entry_ready kg_pulse got %b want 1", kg_start);
    end
    tick();
    kr_hold = 1'b0;
    checks++;
    if ({enc_start, busy} !== 2'b01) begin
      errors++; $display("FAIL entry_ready ignored got %b want 01", {enc_start, busy});
    end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    tick();
    checks++;
    if ({busy, sub_rst_n} !== 2'b01) begin
      errors++; $display("FAIL entry_ready cleanup got %b want 01", {busy, sub_rst_n});
    end
    kg_dly = 3;
  endtask

  initial begin
    test_reset();
    test_run("roundtrip", 16'hA5C3, 16'hA5C3, 1'b0, 3'b100, 13, 1'b1, 123);
    test_run("mismatch", 16'hA5C3, 16'hA5C2, 1'b0, 3'b100, 13, 1'b0, 123);
    test_run("reuse", 16'h1234, 16'h1234, 1'b1, 3'b010, 9, 1'b1, 23);
    kg_dly = 1; enc_dly = 1; dec_dly = 1;
    test_run("back_to_back", 16'h0F0F, 16'h0F0F, 1'b0, 3'b100, 7, 1'b1, 123);
    kg_dly = 3; enc_dly = 3; dec_dly = 3;
    test_timeout();
    test_run("reuse_nokey", 16'h5555, 16'h5555, 1'b1, 3'b100, 13, 1'b1, 123);
    test_abort();
    test_entry_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
